booth_multiplier: RTL and testbench



---
 rtl/booth_multiplier_pkg.sv | 33 +++
 rtl/booth_multiplier_addsub.sv | 30 +++
 rtl/booth_multiplier.sv | 128 ++++++++++++
 tb/tb_booth_multiplier.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_pkg.sv
// rtl/booth_multiplier_pkg.sv - shared types and Booth recoding helpers for the sequential multiplier
package booth_multiplier_pkg;

   // Default operand width; the top exposes WIDTH as a parameter.
   localparam int DEFAULT_WIDTH = 16;

   // Sequencer states: wait for a request, iterate, present the result for one cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Radix-2 Booth recode outcomes for one multiplier bit pair.
   typedef enum logic [1:0] {
      BOOTH_NOP = 2'd0,
      BOOTH_ADD = 2'd1,
      BOOTH_SUB = 2'd2
   } booth_op_t;

   // Map the pair {Q[0], q_1} onto the accumulator operation for this iteration:
   // 01 closes a run of ones (add M), 10 opens one (subtract M), 00/11 leave A alone.
   function automatic booth_op_t booth_recode(input logic q0, input logic q_1);
      booth_op_t op;
      case ({q0, q_1})
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_multiplier_addsub.sv
// rtl/booth_multiplier_addsub.sv - combinational ripple-carry add/subtract used by each Booth iteration
module booth_addsub
   import booth_multiplier_pkg::*;
#(
   parameter int W = DEFAULT_WIDTH + 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] m_i,
   input  logic         f_i,
   output logic [W-1:0] sum_o
);

   // Running carry of the ripple chain; the final carry-out is intentionally dropped
   // because the accumulator carries one guard bit and never needs it.
   logic carry;
   logic mx;

   // Full-adder chain: f=1 turns the add into a subtract by inverting M and injecting a carry.
   always_comb begin
      carry = f_i;
      mx    = 1'b0;
      sum_o = '0;
      for (int i = 0; i < W; i++) begin
         mx       = m_i[i] ^ f_i;
         sum_o[i] = a_i[i] ^ mx ^ carry;
         carry    = (a_i[i] & mx) | (carry & (a_i[i] ^ mx));
      end
   end

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed radix-2 Booth multiplier with start/busy/done handshake
module booth_multiplier
   import booth_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // Iteration counter wide enough to index WIDTH iterations.
   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST_ITR = CW'(WIDTH - 1);

   // Architectural state: M and A carry a guard bit so A-M stays exact for the most negative a.
   state_t                 state_q,   state_d;
   logic [WIDTH:0]         m_q,       m_d;
   logic [WIDTH:0]         acc_q,     acc_d;
   logic [WIDTH-1:0]       q_q,       q_d;
   logic                   q1_q,      q1_d;
   logic [CW-1:0]          count_q,   count_d;
   logic [2*WIDTH-1:0]     product_q, product_d;

   // Datapath for the current iteration.
   booth_op_t              op;
   logic [WIDTH:0]         addsub_sum;
   logic [WIDTH:0]         t_val;
   logic [WIDTH:0]         acc_shift;
   logic [WIDTH-1:0]       q_shift;
   logic                   q1_shift;

   assign op = booth_recode(q_q[0], q1_q);

   booth_addsub #(
      .W     (WIDTH + 1)
   ) u_addsub (
      .a_i   (acc_q),
      .m_i   (m_q),
      .f_i   (op == BOOTH_SUB),
      .sum_o (addsub_sum)
   );

   // Select T and apply the arithmetic right shift of {T, Q, q_1}, replicating A's sign bit.
   always_comb begin
      t_val     = (op == BOOTH_NOP) ? acc_q : addsub_sum;
      acc_shift = {t_val[WIDTH], t_val[WIDTH:1]};
      q_shift   = {t_val[0], q_q[WIDTH-1:1]};
      q1_shift  = q_q[0];
   end

   // Next-state and handshake outputs; every register holds unless the state says otherwise.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      q_d       = q_q;
      q1_d      = q1_q;
      count_d   = count_q;
      product_d = product_q;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = {a[WIDTH-1], a};
               acc_d   = '0;
               q_d     = b;
               q1_d    = 1'b0;
               count_d = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            busy    = 1'b1;
            acc_d   = acc_shift;
            q_d     = q_shift;
            q1_d    = q1_shift;
            count_d = count_q + 1'b1;
            if (count_q == LAST_ITR) begin
               // The guard bit of A is redundant once all iterations are done.
               product_d = {acc_shift[WIDTH-1:0], q_shift};
               state_d   = DONE;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over any request on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - self-checking bench for booth_multiplier
module tb_booth_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;

   booth_multiplier #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] va;
      logic [15:0] vb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference product from plain signed arithmetic.
   function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
      int px;
      int py;
      px = int'($signed(x));
      py = int'($signed(y));
      return 32'(px * py);
   endfunction

   // One operation: start presented for one cycle; optional interfering start at sample pulse_at.
   // lat counts edges from the accepting edge (inclusive) to the first done sample.
   task automatic run_op(input logic [15:0] wa, input logic [15:0] wb, input int pulse_at,
                         output logic [31:0] prod, output logic [31:0] prod_hold,
                         output logic done_hold, output int lat, output int busy_cnt,
                         output int done_cnt, output int overlap);
      int edges;
      prod      = '0;
      prod_hold = '0;
      done_hold = 1'b1;
      lat       = -1;
      busy_cnt  = 0;
      done_cnt  = 0;
      overlap   = 0;
      @(negedge clk);
      a = wa; b = wb; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      start = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      for (int k = 0; k < 45; k++) begin
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (done) begin
            done_cnt++;
            if (lat < 0) begin
               lat  = edges;
               prod = product;
            end
         end
         if (lat >= 0 && edges == lat + 1) begin
            prod_hold = product;
            done_hold = done;
         end
         if (edges == pulse_at) begin
            start = 1'b1; a = 16'h1234; b = 16'h0042;
         end else begin
            start = 1'b0;
         end
         if (lat >= 0 && edges >= lat + 2) break;
         @(posedge clk);
         edges++;
         #1;
      end
      start = 1'b0;
   endtask

   task automatic full_check(input string tag, input logic [15:0] wa, input logic [15:0] wb,
                             input logic [31:0] exp, input int pulse_at);
      logic [31:0] p, ph;
      logic        dh;
      int          lat, bc, dc, ov;
      run_op(wa, wb, pulse_at, p, ph, dh, lat, bc, dc, ov);
      check({tag, " product"},  p, exp);
      check({tag, " latency"},  32'(lat), 32'd17);
      check({tag, " busy_cyc"}, 32'(bc), 32'd16);
      check({tag, " done_cnt"}, 32'(dc), 32'd1);
      check({tag, " overlap"},  32'(ov), 32'd0);
      check({tag, " hold"},     ph, exp);
      check({tag, " done_low"}, 32'(dh), 32'd0);
   endtask

   initial begin
      int first_done;
      int second_done;
      int edges;
      int bad;
      logic [15:0] ra;
      logic [15:0] rb;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
      vecs[1] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
      vecs[2] = '{16'h0001, 16'hFFFF, 32'hFFFFFFFF};
      vecs[3] = '{16'h8000, 16'h8000, 32'h40000000};
      vecs[4] = '{16'h7FFF, 16'h8000, 32'hC0008000};
      vecs[5] = '{16'h8000, 16'h7FFF, 32'hC0008000};
      vecs[6] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      vecs[7] = '{16'h0000, 16'h1234, 32'h00000000};

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset product", product, 32'd0);

      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 16'h0003; b = 16'h0003;
      @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
      check("rst_prio busy", 32'(busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         full_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp, -1);
      end

      // Second start while busy at cycle 5 is ignored.
      full_check("ignore", 16'h0123, 16'h0045, 32'h00004E6F, 5);

      // Abort mid-run with reset: no done pulse afterwards, outputs cleared next cycle.
      @(negedge clk);
      a = 16'h0064; b = 16'h00C8; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("abort busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort product", product, 32'd0);
      bad = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) bad++;
      end
      check("abort no_done", 32'(bad), 32'd0);
      full_check("post_abort", 16'hFFF9, 16'h0006, 32'hFFFFFFD6, -1);

      // Start held high: back-to-back operations every WIDTH+2 cycles.
      @(negedge clk);
      a = 16'h0011; b = 16'hFFF0; start = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      first_done = -1; second_done = -1;
      for (int k = 0; k < 45; k++) begin
         if (done) begin
            if (first_done < 0) first_done = edges;
            else if (second_done < 0) second_done = edges;
         end
         if (edges >= 35) start = 1'b0;
         if (second_done >= 0) break;
         @(posedge clk);
         edges++;
         #1;
      end
      start = 1'b0;
      check("b2b first", 32'(first_done), 32'd17);
      check("b2b second", 32'(second_done), 32'd35);
      check("b2b product", product, model(16'h0011, 16'hFFF0));
      repeat (3) @(posedge clk);

      // Randomised operands against the arithmetic model.
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i == 0) ra = 16'h8000;
         if (i == 1) rb = 16'h8000;
         full_check($sformatf("rand%0d", i), ra, rb, model(ra, rb), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
